// File: rtl/demux_onehot_pkg.sv
// Shared constants and helpers for the one-hot demultiplexer.
//   NLANES     : number of output lanes
//   DEFAULT_DW : default lane payload width
//   ERR_CW     : width of the saturating dropped-transfer counter
//   is_onehot  : legality check for the lane select
package demux_onehot_pkg;

    localparam int unsigned NLANES     = 8;
    localparam int unsigned DEFAULT_DW = 64;
    localparam int unsigned ERR_CW     = 8;

    localparam logic [ERR_CW-1:0] ERR_MAX = '1;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [NLANES-1:0] sel);
        return (sel != '0) && ((sel & (sel - NLANES'(1))) == '0);
    endfunction

endpackage

// File: rtl/demux_onehot_lane.sv
// One-entry valid/data register slice for a single demux lane.
//   clk, nreset : clock, synchronous active-low reset
//   load_i      : write data_i into the slice this edge
//   data_i      : payload to load
//   ready_i     : downstream ready for this lane
//   valid_o     : slice holds a payload (registered)
//   data_o      : held payload, kept after drain (registered)
//   free_c      : slice can take a load this edge (combinational)
module demux_onehot_lane
    import demux_onehot_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          free_c
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    // Empty, or being drained this edge so a reload gives full throughput.
    assign free_c = ~valid_q | ready_i;

    // Drain first, then a load on the same edge overrides it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux_onehot.sv
// One-hot select demultiplexer with a one-entry register per lane.
// Illegal selects (zero or multiple bits) are accepted and dropped,
// flagged by err_pulse and counted in a saturating err_count.
//   clk, nreset         : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake (in_ready combinational)
//   in_sel, in_data     : one-hot lane select and payload
//   out_valid/out_ready : per-lane downstream handshake
//   out_data            : lane i at [DW*i +: DW]
//   err_pulse           : illegal select dropped on the previous edge
//   err_count           : saturating count of dropped transfers
module demux_onehot
    import demux_onehot_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NLANES-1:0]    in_sel,
    input  logic [DW-1:0]        in_data,
    output logic [NLANES-1:0]    out_valid,
    input  logic [NLANES-1:0]    out_ready,
    output logic [NLANES*DW-1:0] out_data,
    output logic                 err_pulse,
    output logic [ERR_CW-1:0]    err_count
);

    logic              sel_legal_c;
    logic [NLANES-1:0] lane_free_c;
    logic [NLANES-1:0] lane_load_c;
    logic              accept_c;
    logic              drop_c;

    logic              err_pulse_q, err_pulse_d;
    logic [ERR_CW-1:0] err_count_q, err_count_d;

    // Select decode and ready mux: only the selected lane's state matters.
    assign sel_legal_c = is_onehot(in_sel);
    assign in_ready    = nreset & (sel_legal_c ? |(in_sel & lane_free_c) : 1'b1);
    assign accept_c    = in_valid & in_ready;
    assign lane_load_c = (accept_c && sel_legal_c) ? in_sel : '0;
    assign drop_c      = accept_c & ~sel_legal_c;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        demux_onehot_lane #(
            .DW(DW)
        ) u_lane (
            .clk    (clk),
            .nreset (nreset),
            .load_i (lane_load_c[i]),
            .data_i (in_data),
            .ready_i(out_ready[i]),
            .valid_o(out_valid[i]),
            .data_o (out_data[DW*i +: DW]),
            .free_c (lane_free_c[i])
        );
    end

    // Dropped-transfer flag and saturating counter.
    always_comb begin
        err_pulse_d = drop_c;
        err_count_d = err_count_q;
        if (drop_c && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: doc/demux_onehot.md
DEMUX_ONEHOT -- requirements
Module: demux_onehot

Interface
REQ-001 Parameter: DW, default 64, data width of each lane in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: nreset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Port: in_valid  input  1  upstream transfer request.
REQ-005 Port: in_ready  output  1  block can accept the presented transfer this cycle.
REQ-006 Port: in_sel  input  8  destination lane select; a legal value is exactly one-hot, bit i selects lane i.
REQ-007 Port: in_data  input  DW  payload.
REQ-008 Port: out_valid  output  8  per-lane valid, bit i for lane i.
REQ-009 Port: out_ready  input  8  per-lane downstream ready.
REQ-010 Port: out_data  output  8*DW  concatenated lane payloads; lane i occupies bits [DW*i +: DW].
REQ-011 Port: err_pulse  output  1  one-cycle flag: illegal select was dropped on the previous edge.
REQ-012 Port: err_count  output  8  saturating count of dropped illegal-select transfers.

Function
REQ-013 Each lane SHALL hold a one-entry register: valid bit plus DW data bits.
REQ-014 Acceptance SHALL occur on an edge where in_valid and in_ready are both 1.
REQ-015 For legal in_sel selecting lane i, in_ready SHALL be combinationally (not out_valid[i]) or out_ready[i].
REQ-016 in_ready SHALL NOT depend on the state of any lane other than the selected one.
REQ-017 Accepting a legal transfer SHALL load in_data into lane i and set out_valid[i] on the same edge; latency is 1 cycle.
REQ-018 A lane SHALL clear out_valid[i] on an edge with out_valid[i] and out_ready[i] both 1, unless it is reloaded on that same edge.
REQ-019 On simultaneous drain and reload of lane i, out_valid[i] SHALL stay 1 and out_data lane i SHALL take the new payload, giving one transfer per cycle per lane.
REQ-020 out_data lane i SHALL hold its last accepted payload while out_valid[i] is 0 and SHALL change only on acceptance.
REQ-021 Illegal in_sel is zero or more than one bit set. For an illegal select, in_ready SHALL be 1 and the transfer SHALL be dropped.
REQ-022 A dropped transfer SHALL leave every lane unchanged.
REQ-023 A dropped transfer SHALL assert err_pulse for exactly the next cycle.
REQ-024 A dropped transfer SHALL increment err_count, which saturates at 255 and never wraps.
REQ-025 in_ready SHALL be evaluated even when in_valid is 0.
REQ-026 in_sel and in_data are don't-care when in_valid is 0; no state changes in that case.
REQ-027 out_valid SHALL NOT be held waiting on out_ready; downstream may drain lanes in any order, and lanes drain independently.

Reset
REQ-028 While nreset is 0 at a rising edge, out_valid, err_pulse and err_count SHALL become 0 and all lane data SHALL become 0.
REQ-029 Reset mid-operation SHALL discard all held payloads with no further handshakes.
REQ-030 in_ready SHALL be 0 while nreset is 0.

Structure
REQ-031 A shared package SHALL hold NLANES = 8, the default DW = 64, the err_count width = 8 and the one-hot legality check function.
REQ-032 One sub-module, demux_onehot_lane (one-entry valid/data register slice with load/drain), SHALL be instantiated NLANES times.
REQ-033 The top level SHALL contain only sel decode, the in_ready mux and the error counter.

Verification
REQ-034 After reset, in_sel=0x04, in_data=0xA5, one cycle valid, out_ready=0 -> out_valid=0x04 next cycle; lane 2 = 0xA5; in_ready=0 for sel 0x04, 1 for sel 0x08.
REQ-035 Lane 5 full, out_ready[5]=1, in_sel=0x20 valid for 4 back-to-back cycles with data 1,2,3,4 -> in_ready=1 every cycle, lane 5 outputs 1,2,3,4 on consecutive cycles, out_valid[5] stays 1.
REQ-036 in_sel=0x00, then 0x81, each valid for one cycle -> in_ready=1; no lane change; err_pulse high one cycle after each; err_count=2.
REQ-037 300 consecutive illegal-select transfers -> err_count reaches 255 and stays 255; err_pulse high each following cycle.
REQ-038 All 8 lanes loaded with 0x10..0x17, nreset=0 for one cycle mid-stream -> out_valid=0, all lane data 0, err_count=0, in_ready=0 during reset.
REQ-039 Random legal/illegal selects with random per-lane out_ready against a scoreboard -> no lost, duplicated or reordered payload per lane; err_count equals the number of illegal acceptances.
